// File: rtl/color_sampler.sv
// Measurement sequencer for the Pmod COLOR interface. Triggers 2^LOG2_SAMPLES
// RGB readings through the ready handshake and publishes their averages.
module color_sampler #(
   parameter int unsigned LOG2_SAMPLES = 2,
   parameter int unsigned TIMEOUT      = 100000,
   parameter int unsigned SHIFT8       = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        continuous,
   input  logic        dev_ready,
   input  logic [15:0] dev_red,
   input  logic [15:0] dev_green,
   input  logic [15:0] dev_blue,
   output logic        measure,
   output logic [15:0] red_avg,
   output logic [15:0] green_avg,
   output logic [15:0] blue_avg,
   output logic [7:0]  red8,
   output logic [7:0]  green8,
   output logic [7:0]  blue8,
   output logic        valid,
   output logic        busy,
   output logic        timeout_err
);

   localparam int unsigned ACC_W = 16 + LOG2_SAMPLES;
   localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
   localparam int unsigned CNT_W = LOG2_SAMPLES + 1;
   localparam int unsigned N     = 1 << LOG2_SAMPLES;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_ACCUM,
      S_OUTPUT
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic               w_run_start;
   logic               w_set_err;
   logic               w_tmo;
   logic [TMR_W-1:0]   r_timer;
   logic [CNT_W-1:0]   r_cnt;
   logic [ACC_W-1:0]   r_acc_r;
   logic [ACC_W-1:0]   r_acc_g;
   logic [ACC_W-1:0]   r_acc_b;
   logic [15:0]        r_red_avg;
   logic [15:0]        r_green_avg;
   logic [15:0]        r_blue_avg;
   logic [7:0]         r_red8;
   logic [7:0]         r_green8;
   logic [7:0]         r_blue8;
   logic               r_valid;
   logic               r_timeout_err;
   logic [15:0]        w_avg_r;
   logic [15:0]        w_avg_g;
   logic [15:0]        w_avg_b;

   // Clamp the shifted average into an 8-bit channel.
   function automatic logic [7:0] f_sat8(input logic [15:0] a);
      logic [15:0] s;
      s = a >> SHIFT8;
      return (s > 16'd255) ? 8'hFF : s[7:0];
   endfunction

   // Dividing by 2^LOG2_SAMPLES is just dropping the low accumulator bits.
   assign w_avg_r = r_acc_r[ACC_W-1:LOG2_SAMPLES];
   assign w_avg_g = r_acc_g[ACC_W-1:LOG2_SAMPLES];
   assign w_avg_b = r_acc_b[ACC_W-1:LOG2_SAMPLES];
   assign w_tmo   = (r_timer == TMR_W'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_run_start = 1'b0;
      w_set_err   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start || continuous) begin
               w_next      = S_TRIG;
               w_run_start = 1'b1;
            end
         end
         S_TRIG: begin
            if (dev_ready) w_next = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (!dev_ready) begin
               w_next = S_WAIT_DONE;
            end else if (w_tmo) begin
               w_next    = S_TRIG;
               w_set_err = 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (dev_ready) begin
               w_next = S_ACCUM;
            end else if (w_tmo) begin
               w_next    = S_IDLE;
               w_set_err = 1'b1;
            end
         end
         S_ACCUM:  w_next = (r_cnt == CNT_W'(N - 1)) ? S_OUTPUT : S_TRIG;
         S_OUTPUT: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Per-phase timer: restarts on every state change, parks at TIMEOUT.
   always_ff @(posedge clk) begin
      if (rst || (w_next != r_state))        r_timer <= '0;
      else if (r_timer != TMR_W'(TIMEOUT))   r_timer <= r_timer + TMR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt         <= '0;
         r_acc_r       <= '0;
         r_acc_g       <= '0;
         r_acc_b       <= '0;
         r_red_avg     <= '0;
         r_green_avg   <= '0;
         r_blue_avg    <= '0;
         r_red8        <= '0;
         r_green8      <= '0;
         r_blue8       <= '0;
         r_valid       <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_run_start) begin
            r_cnt         <= '0;
            r_acc_r       <= '0;
            r_acc_g       <= '0;
            r_acc_b       <= '0;
            r_timeout_err <= 1'b0;
         end
         if (w_set_err) r_timeout_err <= 1'b1;
         if (r_state == S_ACCUM) begin
            r_acc_r <= r_acc_r + ACC_W'(dev_red);
            r_acc_g <= r_acc_g + ACC_W'(dev_green);
            r_acc_b <= r_acc_b + ACC_W'(dev_blue);
            r_cnt   <= r_cnt + CNT_W'(1);
         end
         if (r_state == S_OUTPUT) begin
            r_red_avg   <= w_avg_r;
            r_green_avg <= w_avg_g;
            r_blue_avg  <= w_avg_b;
            r_red8      <= f_sat8(w_avg_r);
            r_green8    <= f_sat8(w_avg_g);
            r_blue8     <= f_sat8(w_avg_b);
            r_valid     <= 1'b1;
         end
      end
   end

   // The request follows ready within the cycle so it is never raised against a busy device.
   assign measure     = (r_state == S_TRIG) && dev_ready && !rst;
   assign busy        = (r_state != S_IDLE);
   assign valid       = r_valid;
   assign timeout_err = r_timeout_err;
   assign red_avg     = r_red_avg;
   assign green_avg   = r_green_avg;
   assign blue_avg    = r_blue_avg;
   assign red8        = r_red8;
   assign green8      = r_green8;
   assign blue8       = r_blue8;

endmodule

// File: tb/tb_color_sampler.sv
// Bench for color_sampler: behavioural COLOR-device model plus a sum/divide
// reference, driving two instances that differ only in SHIFT8 (8 and 4).
module tb_color_sampler;

   localparam int unsigned N   = 4;
   localparam int unsigned TMO = 200;
   localparam int M_NORMAL  = 0;
   localparam int M_NODROP  = 1;
   localparam int M_NORAISE = 2;

   typedef struct packed {
      logic [15:0] r;
      logic [15:0] g;
      logic [15:0] b;
   } smp_t;

   logic        clk;
   logic        rst, start, continuous, hold_low, dev_rdy_m;
   logic        dev_ready;
   logic [15:0] dev_red, dev_green, dev_blue;

   logic        measure_a, valid_a, busy_a, timeout_err_a;
   logic [15:0] red_avg_a, green_avg_a, blue_avg_a;
   logic [7:0]  red8_a, green8_a, blue8_a;
   logic        measure_b, valid_b, busy_b, timeout_err_b;
   logic [15:0] red_avg_b, green_avg_b, blue_avg_b;
   logic [7:0]  red8_b, green8_b, blue8_b;

   int   n_cmp = 0;
   int   n_err = 0;
   int   meas_cnt = 0;
   int   valid_cnt = 0;
   int   low_run = 0;
   int   gaps[$];
   int   dev_mode;
   logic dev_abort;
   int   drop_dly, high_dly;
   smp_t smp_q[$];
   smp_t cur[N];
   smp_t dev_s;

   assign dev_ready = dev_rdy_m & ~hold_low;

   color_sampler #(.LOG2_SAMPLES(2), .TIMEOUT(TMO), .SHIFT8(8)) dut_a (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous),
      .dev_ready(dev_ready), .dev_red(dev_red), .dev_green(dev_green), .dev_blue(dev_blue),
      .measure(measure_a), .red_avg(red_avg_a), .green_avg(green_avg_a), .blue_avg(blue_avg_a),
      .red8(red8_a), .green8(green8_a), .blue8(blue8_a),
      .valid(valid_a), .busy(busy_a), .timeout_err(timeout_err_a)
   );

   color_sampler #(.LOG2_SAMPLES(2), .TIMEOUT(TMO), .SHIFT8(4)) dut_b (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous),
      .dev_ready(dev_ready), .dev_red(dev_red), .dev_green(dev_green), .dev_blue(dev_blue),
      .measure(measure_b), .red_avg(red_avg_b), .green_avg(green_avg_b), .blue_avg(blue_avg_b),
      .red8(red8_b), .green8(green8_b), .blue8(blue8_b),
      .valid(valid_b), .busy(busy_b), .timeout_err(timeout_err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int unsigned m_sat8(input int unsigned avg, input int unsigned sh);
      int unsigned v;
      v = avg >> sh;
      return (v > 255) ? 255 : v;
   endfunction

   // Pulse/handshake monitor on the falling edge, away from DUT updates.
   always @(negedge clk) begin
      if (measure_a) meas_cnt <= meas_cnt + 1;
      if (valid_a)   valid_cnt <= valid_cnt + 1;
      if (!busy_a) begin
         low_run <= low_run + 1;
      end else begin
         if (low_run > 0) gaps.push_back(low_run);
         low_run <= 0;
      end
   end

   // COLOR device: drop ready drop_dly cycles after measure, raise it high_dly later with data.
   initial begin
      dev_rdy_m = 1'b1;
      dev_red   = '0;
      dev_green = '0;
      dev_blue  = '0;
      forever begin
         @(negedge clk);
         if (measure_a && dev_mode != M_NODROP) begin
            repeat (drop_dly) @(posedge clk);
            #1 dev_rdy_m = 1'b0;
            for (int k = 0; (k < high_dly || dev_mode == M_NORAISE) && !dev_abort; k++)
               @(posedge clk);
            #1;
            if (!dev_abort && smp_q.size() > 0) begin
               dev_s     = smp_q.pop_front();
               dev_red   = dev_s.r;
               dev_green = dev_s.g;
               dev_blue  = dev_s.b;
            end
            dev_rdy_m = 1'b1;
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clk);
         if (!busy_a) break;
      end
      chk({tag, ".idle"}, 32'(busy_a), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic load_cur();
      smp_q.delete();
      for (int i = 0; i < N; i++) smp_q.push_back(cur[i]);
   endtask

   task automatic rand_cur(input int unsigned lo);
      for (int i = 0; i < N; i++) begin
         cur[i].r = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(lo, 65535));
         cur[i].g = 16'($urandom_range(lo, 65535));
         cur[i].b = 16'($urandom_range(lo, 4095));
      end
   endtask

   // Reference averages straight from the sample set.
   task automatic check_vals(input string tag);
      int unsigned sr = 0, sg = 0, sb = 0, er, eg, eb;
      for (int i = 0; i < N; i++) begin
         sr += 32'(cur[i].r);
         sg += 32'(cur[i].g);
         sb += 32'(cur[i].b);
      end
      er = sr / N;
      eg = sg / N;
      eb = sb / N;
      chk({tag, ".red_avg"},   32'(red_avg_a),   er);
      chk({tag, ".green_avg"}, 32'(green_avg_a), eg);
      chk({tag, ".blue_avg"},  32'(blue_avg_a),  eb);
      chk({tag, ".red8_s8"},   32'(red8_a),   m_sat8(er, 8));
      chk({tag, ".green8_s8"}, 32'(green8_a), m_sat8(eg, 8));
      chk({tag, ".blue8_s8"},  32'(blue8_a),  m_sat8(eb, 8));
      chk({tag, ".red8_s4"},   32'(red8_b),   m_sat8(er, 4));
      chk({tag, ".green8_s4"}, 32'(green8_b), m_sat8(eg, 4));
      chk({tag, ".blue8_s4"},  32'(blue8_b),  m_sat8(eb, 4));
      chk({tag, ".red_avg_s4"}, 32'(red_avg_b), er);
   endtask

   task automatic run_check(input string tag);
      int m0, v0;
      load_cur();
      m0 = meas_cnt;
      v0 = valid_cnt;
      pulse_start();
      wait_idle(tag, 3000);
      chk({tag, ".measures"}, 32'(meas_cnt - m0), 32'(N));
      chk({tag, ".valids"},   32'(valid_cnt - v0), 32'd1);
      check_vals(tag);
   endtask

   initial begin : main
      int k, m0, v0, vs, g0;
      logic [15:0] ra, ga, ba;
      logic [7:0]  r8;
      rst = 1'b1; start = 1'b0; continuous = 1'b0; hold_low = 1'b0;
      dev_mode = M_NORMAL; dev_abort = 1'b0; drop_dly = 10; high_dly = 50;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst.measure", 32'(measure_a), 32'd0);
      chk("rst.red_avg", 32'(red_avg_a), 32'd0);
      chk("rst.green_avg", 32'(green_avg_a), 32'd0);
      chk("rst.blue_avg", 32'(blue_avg_a), 32'd0);
      chk("rst.red8", 32'(red8_a), 32'd0);
      chk("rst.valid", 32'(valid_a), 32'd0);
      chk("rst.busy", 32'(busy_a), 32'd0);
      chk("rst.timeout_err", 32'(timeout_err_a), 32'd0);
      chk("rst.b_outs", {measure_b, valid_b, busy_b, timeout_err_b, green_avg_b, 12'(blue_avg_b)}, 32'd0);

      // Directed ramp 100..400.
      for (int i = 0; i < N; i++) begin
         cur[i].r = 16'(100 * (i + 1));
         cur[i].g = 16'($urandom);
         cur[i].b = 16'($urandom);
      end
      run_check("ramp");
      chk("ramp.red_250", 32'(red_avg_a), 32'd250);

      for (int i = 0; i < N; i++) cur[i] = {16'hFFFF, 16'hFFFF, 16'hFFFF};
      run_check("full");
      chk("full.red_avg", 32'(red_avg_a), 32'hFFFF);
      chk("full.red8_s8", 32'(red8_a), 32'd255);
      chk("full.red8_s4", 32'(red8_b), 32'd255);

      for (int i = 0; i < N; i++) cur[i] = {16'h0ABC, 16'h0ABC, 16'h0ABC};
      run_check("abc");
      chk("abc.red8_s4", 32'(red8_b), 32'hAB);

      for (int r = 0; r < 6; r++) begin
         drop_dly = $urandom_range(1, 20);
         high_dly = $urandom_range(1, 50);
         rand_cur(0);
         run_check($sformatf("rand%0d", r));
      end
      drop_dly = 10;
      high_dly = 50;

      // Ready low at start: no request until the device is ready.
      rand_cur(1);
      load_cur();
      @(posedge clk); #1 hold_low = 1'b1;
      m0 = meas_cnt;
      v0 = valid_cnt;
      pulse_start();
      repeat (6) @(negedge clk);
      @(posedge clk); #1;
      chk("rdylow.no_measure", 32'(meas_cnt - m0), 32'd0);
      chk("rdylow.busy", 32'(busy_a), 32'd1);
      hold_low = 1'b0;
      @(negedge clk);
      chk("rdylow.measure_first", 32'(measure_a), 32'd1);
      wait_idle("rdylow", 3000);
      chk("rdylow.valids", 32'(valid_cnt - v0), 32'd1);
      check_vals("rdylow");

      // Start pulsed mid-run is ignored.
      rand_cur(1);
      load_cur();
      m0 = meas_cnt;
      v0 = valid_cnt;
      pulse_start();
      for (k = 0; k < 200; k++) begin
         @(posedge clk); #1;
         if (!dev_ready) break;
      end
      repeat (5) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_idle("midstart", 3000);
      chk("midstart.measures", 32'(meas_cnt - m0), 32'(N));
      chk("midstart.valids", 32'(valid_cnt - v0), 32'd1);
      check_vals("midstart");
      repeat (5) @(negedge clk);
      chk("midstart.stay_idle", 32'(busy_a), 32'd0);

      // Continuous: three back-to-back runs.
      smp_q.delete();
      for (int r = 0; r < 3; r++) begin
         rand_cur(0);
         for (int i = 0; i < N; i++) smp_q.push_back(cur[i]);
      end
      g0 = gaps.size();
      m0 = meas_cnt;
      v0 = valid_cnt;
      vs = 0;
      @(posedge clk); #1 continuous = 1'b1;
      for (k = 0; k < 5000 && vs < 3; k++) begin
         @(negedge clk);
         if (valid_a) vs++;
      end
      continuous = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("cont.valids", 32'(valid_cnt - v0), 32'd3);
      chk("cont.measures", 32'(meas_cnt - m0), 32'(3 * N));
      chk("cont.busy_end", 32'(busy_a), 32'd0);
      chk("cont.gap_cnt", 32'(gaps.size() - g0), 32'd3);
      if (gaps.size() >= g0 + 3) begin
         chk("cont.gap1", 32'(gaps[g0 + 1]), 32'd1);
         chk("cont.gap2", 32'(gaps[g0 + 2]), 32'd1);
      end
      check_vals("cont");

      // Device never acknowledges: retry with timeout flagged, still busy.
      rand_cur(1);
      load_cur();
      dev_mode = M_NODROP;
      m0 = meas_cnt;
      v0 = valid_cnt;
      pulse_start();
      repeat (3 * TMO) @(posedge clk);
      #1;
      chk("nodrop.timeout_err", 32'(timeout_err_a), 32'd1);
      chk("nodrop.busy", 32'(busy_a), 32'd1);
      chk("nodrop.repulse", 32'(meas_cnt - m0 >= 2), 32'd1);
      chk("nodrop.no_valid", 32'(valid_cnt - v0), 32'd0);
      dev_mode = M_NORMAL;
      wait_idle("nodrop", 4000);
      chk("nodrop.valids", 32'(valid_cnt - v0), 32'd1);
      chk("nodrop.err_sticky", 32'(timeout_err_a), 32'd1);
      check_vals("nodrop");

      // Device never finishes: run aborts, averages held.
      smp_q.delete();
      ra = red_avg_a;
      ga = green_avg_a;
      ba = blue_avg_a;
      r8 = red8_b;
      v0 = valid_cnt;
      dev_mode = M_NORAISE;
      pulse_start();
      wait_idle("noraise", 4 * TMO + 200);
      chk("noraise.timeout_err", 32'(timeout_err_a), 32'd1);
      chk("noraise.no_valid", 32'(valid_cnt - v0), 32'd0);
      chk("noraise.red_held", 32'(red_avg_a), 32'(ra));
      chk("noraise.green_held", 32'(green_avg_a), 32'(ga));
      chk("noraise.blue_held", 32'(blue_avg_a), 32'(ba));
      chk("noraise.red8_held", 32'(red8_b), 32'(r8));
      dev_abort = 1'b1;
      for (k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (dev_rdy_m) break;
      end
      dev_abort = 1'b0;
      dev_mode = M_NORMAL;

      // New run clears the error; reset during WAIT_DONE clears everything.
      rand_cur(1);
      load_cur();
      pulse_start();
      @(posedge clk); #1;
      chk("rstmid.err_cleared", 32'(timeout_err_a), 32'd0);
      for (k = 0; k < 200; k++) begin
         @(posedge clk); #1;
         if (!dev_ready) break;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      chk("rstmid.busy", 32'(busy_a), 32'd0);
      chk("rstmid.measure", 32'(measure_a), 32'd0);
      chk("rstmid.avgs", {red_avg_a, green_avg_a | blue_avg_a}, 32'd0);
      chk("rstmid.ch8", {8'd0, red8_a, green8_a, blue8_a}, 32'd0);
      chk("rstmid.valid_err", {30'd0, valid_a, timeout_err_a}, 32'd0);
      chk("rstmid.b_avg", 32'(red_avg_b), 32'd0);
      rst = 1'b0;
      for (k = 0; k < 200; k++) begin
         @(posedge clk); #1;
         if (dev_rdy_m) break;
      end
      smp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      chk("rstmid.stay_idle", 32'(busy_a), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
